// File: rtl/gfx_fixed_muladd_lanes.sv
// Per-lane signed fixed-point q = a*b + c. It has a ready/valid pipeline DEPTH stages deep.
// Stage 1 multiplies, stage 2 rounds/shifts/adds, stage 3 clamps/masks, and the rest are delay stages.
module gfx_fixed_muladd_lanes #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned WORD_BITS = 32,
  parameter int unsigned FRAC_BITS = 10,
  parameter int unsigned DEPTH     = 5,
  parameter int unsigned TAG_BITS  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*WORD_BITS-1:0] in_a,
  input  logic [LANES*WORD_BITS-1:0] in_b,
  input  logic [LANES*WORD_BITS-1:0] in_c,
  input  logic [LANES-1:0]           in_mask,
  input  logic                       in_sat,
  input  logic                       in_round,
  input  logic [TAG_BITS-1:0]        in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*WORD_BITS-1:0] out_q,
  output logic [LANES-1:0]           out_mask,
  output logic [LANES-1:0]           out_ovf,
  output logic [TAG_BITS-1:0]        out_tag
);

  localparam int unsigned W    = WORD_BITS;
  localparam int unsigned F    = FRAC_BITS;
  localparam int unsigned PW   = 2 * W;
  localparam int unsigned EW   = 2 * W + 1;
  localparam int unsigned SW   = 2 * W - F + 1;
  localparam int unsigned TAIL = DEPTH - 2;

  localparam logic signed [EW-1:0] HALF = EW'(1) << (F - 1);
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  // stage 1: exact products
  logic                          s1_v_q;
  logic [LANES-1:0][PW-1:0]      s1_p_q, s1_p_d;
  logic [LANES-1:0][W-1:0]       s1_c_q;
  logic [LANES-1:0]              s1_mask_q;
  logic                          s1_sat_q, s1_rnd_q;
  logic [TAG_BITS-1:0]           s1_tag_q;

  // stage 2: rounded, shifted sum
  logic                          s2_v_q;
  logic [LANES-1:0][SW-1:0]      s2_s_q, s2_s_d;
  logic [LANES-1:0]              s2_mask_q;
  logic                          s2_sat_q;
  logic [TAG_BITS-1:0]           s2_tag_q;

  // stage 3 onward: final results
  logic [TAIL-1:0]                     t_v_q;
  logic [TAIL-1:0][LANES*W-1:0]        t_q_q;
  logic [TAIL-1:0][LANES-1:0]          t_ovf_q, t_mask_q;
  logic [TAIL-1:0][TAG_BITS-1:0]       t_tag_q;
  logic [LANES*W-1:0]                  q3_d;
  logic [LANES-1:0]                    ovf3_d;

  logic adv;

  assign adv      = ~t_v_q[TAIL-1] | out_ready;
  assign in_ready = adv;

  always_comb begin
    logic signed [PW-1:0] ea, eb;
    s1_p_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      ea = PW'($signed(in_a[i*W +: W]));
      eb = PW'($signed(in_b[i*W +: W]));
      s1_p_d[i] = ea * eb;
    end
  end

  always_comb begin
    logic signed [EW-1:0] pr, r, radd;
    s2_s_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      radd = s1_rnd_q ? HALF : '0;
      pr   = EW'($signed(s1_p_q[i])) + radd;
      r    = pr >>> F;
      // the sum always fits in SW bits, so dropping the top of the EW-bit sum loses nothing
      s2_s_d[i] = SW'(r + EW'($signed(s1_c_q[i])));
    end
  end

  always_comb begin
    logic [SW-1:0]  sv;
    logic [SW-W:0]  hi;
    logic           in_range;
    q3_d   = '0;
    ovf3_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sv       = s2_s_q[i];
      hi       = sv[SW-1:W-1];
      in_range = (&hi) | ~(|hi);
      ovf3_d[i] = s2_mask_q[i] & ~in_range;
      if (!s2_mask_q[i])
        q3_d[i*W +: W] = '0;
      else if (s2_sat_q && !in_range)
        q3_d[i*W +: W] = sv[SW-1] ? MINV : MAXV;
      else
        q3_d[i*W +: W] = sv[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_p_q    <= '0;
      s1_c_q    <= '0;
      s1_mask_q <= '0;
      s1_sat_q  <= 1'b0;
      s1_rnd_q  <= 1'b0;
      s1_tag_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_s_q    <= '0;
      s2_mask_q <= '0;
      s2_sat_q  <= 1'b0;
      s2_tag_q  <= '0;
      t_v_q     <= '0;
      t_q_q     <= '0;
      t_ovf_q   <= '0;
      t_mask_q  <= '0;
      t_tag_q   <= '0;
    end else if (adv) begin
      s1_v_q    <= in_valid;
      s1_p_q    <= s1_p_d;
      for (int unsigned i = 0; i < LANES; i++)
        s1_c_q[i] <= in_c[i*W +: W];
      s1_mask_q <= in_mask;
      s1_sat_q  <= in_sat;
      s1_rnd_q  <= in_round;
      s1_tag_q  <= in_tag;

      s2_v_q    <= s1_v_q;
      s2_s_q    <= s2_s_d;
      s2_mask_q <= s1_mask_q;
      s2_sat_q  <= s1_sat_q;
      s2_tag_q  <= s1_tag_q;

      t_v_q[0]    <= s2_v_q;
      t_q_q[0]    <= q3_d;
      t_ovf_q[0]  <= ovf3_d;
      t_mask_q[0] <= s2_mask_q;
      t_tag_q[0]  <= s2_tag_q;
      for (int unsigned k = 1; k < TAIL; k++) begin
        t_v_q[k]    <= t_v_q[k-1];
        t_q_q[k]    <= t_q_q[k-1];
        t_ovf_q[k]  <= t_ovf_q[k-1];
        t_mask_q[k] <= t_mask_q[k-1];
        t_tag_q[k]  <= t_tag_q[k-1];
      end
    end
  end

  assign out_valid = t_v_q[TAIL-1];
  assign out_q     = t_q_q[TAIL-1];
  assign out_ovf   = t_ovf_q[TAIL-1];
  assign out_mask  = t_mask_q[TAIL-1];
  assign out_tag   = t_tag_q[TAIL-1];

endmodule

// File: tb/tb_gfx_fixed_muladd_lanes.sv
// Self-checking bench for gfx_fixed_muladd_lanes. It combines directed vectors with latency checks,
// backpressure and reset sequences, and random traffic checked against a longint arithmetic model.
module tb_gfx_fixed_muladd_lanes;
  localparam int unsigned LANES = 4;
  localparam int unsigned W     = 32;
  localparam int unsigned F     = 10;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned TB    = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [LANES*W-1:0]   in_a = '0, in_b = '0, in_c = '0;
  logic [LANES-1:0]     in_mask = '0;
  logic                 in_sat = 1'b0, in_round = 1'b0;
  logic [TB-1:0]        in_tag = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [LANES*W-1:0]   out_q;
  logic [LANES-1:0]     out_mask, out_ovf;
  logic [TB-1:0]        out_tag;

  gfx_fixed_muladd_lanes #(
    .LANES(LANES), .WORD_BITS(W), .FRAC_BITS(F), .DEPTH(DEPTH), .TAG_BITS(TB)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_mask(in_mask), .in_sat(in_sat), .in_round(in_round), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_mask(out_mask), .out_ovf(out_ovf), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [127:0] q;
    logic [3:0]   ovf;
    logic [3:0]   mask;
    logic [3:0]   tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] a, b, c;
    logic [3:0]  mask;
    logic        sat, rnd;
    logic [3:0]  tag;
    logic [31:0] eq;
    logic        eovf;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic on 64-bit signed values
  function automatic void model(input logic [127:0] a, b, c, input logic [3:0] mask,
                                input logic sat, rnd,
                                output logic [127:0] q, output logic [3:0] ovf);
    q = '0;
    ovf = '0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] al, bl, cl, ql;
      longint p, s;
      logic o;
      al = a[i*32 +: 32];
      bl = b[i*32 +: 32];
      cl = c[i*32 +: 32];
      p = longint'($signed(al)) * longint'($signed(bl));
      if (rnd) p = p + (64'sd1 << (F - 1));
      s = (p >>> F) + longint'($signed(cl));
      o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      if (sat && s > 64'sd2147483647)       ql = 32'h7FFFFFFF;
      else if (sat && s < -64'sd2147483648) ql = 32'h80000000;
      else                                  ql = s[31:0];
      q[i*32 +: 32] = mask[i] ? ql : 32'h0;
      ovf[i] = mask[i] & o;
    end
  endfunction

  // Scoreboard: inputs are stable from posedge+1, so the negedge sees what the next edge will act on
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("stale_output", {127'h0, out_valid}, 128'h0);
        end else begin
          e = sb.pop_front();
          chk("sb_q", out_q, e.q);
          chk("sb_ovf", {124'h0, out_ovf}, {124'h0, e.ovf});
          chk("sb_mask", {124'h0, out_mask}, {124'h0, e.mask});
          chk("sb_tag", {124'h0, out_tag}, {124'h0, e.tag});
        end
      end
      if (in_valid && in_ready) begin
        model(in_a, in_b, in_c, in_mask, in_sat, in_round, e.q, e.ovf);
        e.mask = in_mask;
        e.tag  = in_tag;
        sb.push_back(e);
      end
    end
  end

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: return w;
      1: return {{20{w[11]}}, w[11:0]};
      2: return {1'b0, {31{1'b1}}} - {30'h0, w[1:0]};
      default: return {1'b1, 19'h0, w[11:0]};
    endcase
  endfunction

  task automatic rand_operands();
    for (int i = 0; i < 4; i++) begin
      in_a[i*32 +: 32] = rnd_word();
      in_b[i*32 +: 32] = rnd_word();
      in_c[i*32 +: 32] = rnd_word();
    end
    in_mask  = 4'($urandom);
    in_sat   = 1'($urandom);
    in_round = 1'($urandom);
  endtask

  // One transaction with the output always ready. It checks accept, latency and the expected table values.
  task automatic apply_vec(input vec_t v, input string nm);
    logic [127:0] eq;
    logic [3:0]   eo;
    int n;
    for (int i = 0; i < 4; i++) begin
      eq[i*32 +: 32] = v.mask[i] ? v.eq : 32'h0;
      eo[i] = v.mask[i] & v.eovf;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_a = {4{v.a}}; in_b = {4{v.b}}; in_c = {4{v.c}};
    in_mask = v.mask; in_sat = v.sat; in_round = v.rnd; in_tag = v.tag;
    in_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_accept"}, {127'h0, in_ready}, 128'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 30);
    chk({nm, "_latency"}, n, DEPTH);
    chk({nm, "_q"}, out_q, eq);
    chk({nm, "_ovf"}, {124'h0, out_ovf}, {124'h0, eo});
    chk({nm, "_mask"}, {124'h0, out_mask}, {124'h0, v.mask});
    chk({nm, "_tag"}, {124'h0, out_tag}, {124'h0, v.tag});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    int k, got, viol, bad_order, stale;

    //          a             b             c             mask     sat   rnd   tag    eq            eovf
    vt[0] = '{32'h00000600, 32'h00000800, 32'h00000100, 4'b1111, 1'b1, 1'b1, 4'h1, 32'h00000D00, 1'b0};
    vt[1] = '{32'h7FFFFFFF, 32'h00000800, 32'h00000000, 4'b1111, 1'b1, 1'b1, 4'h2, 32'h7FFFFFFF, 1'b1};
    vt[2] = '{32'h7FFFFFFF, 32'h00000800, 32'h00000000, 4'b1111, 1'b0, 1'b0, 4'h3, 32'hFFFFFFFE, 1'b1};
    vt[3] = '{32'h80000000, 32'h00000800, 32'h00000000, 4'b1111, 1'b1, 1'b0, 4'h4, 32'h80000000, 1'b1};
    vt[4] = '{32'h80000000, 32'h00000800, 32'h00000000, 4'b1111, 1'b0, 1'b0, 4'h5, 32'h00000000, 1'b1};
    vt[5] = '{32'h00000001, 32'h00000200, 32'h00000000, 4'b1111, 1'b1, 1'b1, 4'h6, 32'h00000001, 1'b0};
    vt[6] = '{32'h00000001, 32'h00000200, 32'h00000000, 4'b1111, 1'b1, 1'b0, 4'h7, 32'h00000000, 1'b0};
    vt[7] = '{32'hFFFFFFFF, 32'h00000200, 32'h00000000, 4'b1111, 1'b1, 1'b1, 4'h8, 32'h00000000, 1'b0};
    vt[8] = '{32'hFFFFFFFF, 32'h00000200, 32'h00000000, 4'b1111, 1'b1, 1'b0, 4'h9, 32'hFFFFFFFF, 1'b0};
    vt[9] = '{32'h7FFFFFFF, 32'h00000800, 32'h00000000, 4'b0101, 1'b0, 1'b1, 4'hA, 32'hFFFFFFFE, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {127'h0, out_valid}, 128'h0);
    chk("reset_out_q", out_q, 128'h0);
    chk("reset_out_misc", {116'h0, out_mask, out_ovf, out_tag}, 128'h0);
    chk("reset_in_ready", {127'h0, in_ready}, 128'h1);

    for (int i = 0; i < 10; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

    // Backpressure: fill while stalled, then drain in order
    k = 0; viol = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      rand_operands();
      in_valid = (k < 8);
      in_tag = k[3:0];
      @(negedge clk);
      if (in_ready !== !out_valid) viol++;
      if (in_valid && in_ready) k++;
    end
    chk("bp_held", k, DEPTH);
    chk("bp_ready_follows_valid", viol, 0);
    chk("bp_out_valid", {127'h0, out_valid}, 128'h1);
    got = 0; bad_order = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      rand_operands();
      in_valid = (k < 8);
      in_tag = k[3:0];
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (out_tag !== got[3:0]) bad_order++;
        got++;
      end
      if (in_valid && in_ready) k++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_drained", got, 8);
    chk("bp_order", bad_order, 0);
    chk("bp_all_accepted", k, 8);

    // Reset with three transactions in flight
    repeat (3) begin
      @(posedge clk); #1;
      rand_operands();
      in_mask = 4'hF;
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", {127'h0, out_valid}, 128'h0);
    chk("midreset_out_q", out_q, 128'h0);
    chk("midreset_out_misc", {116'h0, out_mask, out_ovf, out_tag}, 128'h0);
    chk("midreset_in_ready", {127'h0, in_ready}, 128'h1);
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("midreset_no_stale", stale, 0);
    apply_vec(vt[0], "post_reset");

    // Random traffic with random backpressure
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk); #1;
      rand_operands();
      in_tag    = 4'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3 * DEPTH) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    chk("drain_out_valid", {127'h0, out_valid}, 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
